// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: register file geometry, producer latencies
// and the operand forward-select encodings used by the hazard logic.
package cpu_pkg;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int STAGES  = 3;
    localparam int LAT_W   = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    function automatic int sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_slot_match.sv
// Youngest-first search of the in-flight slots for one source operand.
// ready_o is low only when the matching producer still needs more than one shift.
module fwd_slot_match
    import cpu_pkg::*;
#(
    parameter int STAGES_P = STAGES,
    parameter int REG_AW_P = REG_AW,
    parameter int LAT_W_P  = LAT_W,
    parameter int SEL_W_P  = sel_w(STAGES)
) (
    input  logic [STAGES_P-1:0]          valid_i,
    input  logic [STAGES_P*REG_AW_P-1:0] rd_i,
    input  logic [STAGES_P*LAT_W_P-1:0]  cnt_i,
    input  logic [REG_AW_P-1:0]          rs_i,
    input  logic                         used_i,
    output logic                         hit_o,
    output logic [SEL_W_P-1:0]           idx_o,
    output logic                         ready_o
);

    always_comb begin
        hit_o   = 1'b0;
        idx_o   = '0;
        ready_o = 1'b1;
        // Scan oldest to youngest so the youngest match overwrites the rest.
        for (int i = STAGES_P - 1; i >= 0; i--) begin
            if (valid_i[i] && used_i && (rs_i != '0) &&
                (rd_i[i*REG_AW_P +: REG_AW_P] == rs_i)) begin
                hit_o   = 1'b1;
                idx_o   = SEL_W_P'(i);
                ready_o = (cnt_i[i*LAT_W_P +: LAT_W_P] <= LAT_W_P'(1));
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations per slot
// and emits a stall or registered forward selects for the ID instruction.
module fwd_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_AW_P  = REG_AW,
    parameter int NUM_SRC_P = NUM_SRC,
    parameter int STAGES_P  = STAGES,
    parameter int LAT_W_P   = LAT_W
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     freeze_i,
    input  logic                                     issue_valid_i,
    input  logic [REG_AW_P-1:0]                      issue_rd_i,
    input  logic                                     issue_wr_i,
    input  logic [LAT_W_P-1:0]                       issue_lat_i,
    input  logic [NUM_SRC_P*REG_AW_P-1:0]            issue_rs_i,
    input  logic [NUM_SRC_P-1:0]                     issue_rs_used_i,
    output logic                                     stall_o,
    output logic [NUM_SRC_P*sel_w(STAGES_P)-1:0]     fwd_sel_o
);

    localparam int SEL_W = sel_w(STAGES_P);

    logic [STAGES_P-1:0]               valid_q, valid_d;
    logic [STAGES_P-1:0][REG_AW_P-1:0] rd_q, rd_d;
    logic [STAGES_P-1:0][LAT_W_P-1:0]  cnt_q, cnt_d;
    logic [NUM_SRC_P*SEL_W-1:0]        sel_q, sel_d;

    logic [NUM_SRC_P-1:0]            hit;
    logic [NUM_SRC_P-1:0]            ready;
    logic [NUM_SRC_P-1:0][SEL_W-1:0] idx;
    logic [NUM_SRC_P-1:0][SEL_W-1:0] nsel;
    logic                            accept;

    for (genvar k = 0; k < NUM_SRC_P; k++) begin : g_src
        fwd_slot_match #(
            .STAGES_P (STAGES_P),
            .REG_AW_P (REG_AW_P),
            .LAT_W_P  (LAT_W_P),
            .SEL_W_P  (SEL_W)
        ) u_match (
            .valid_i (valid_q),
            .rd_i    (rd_q),
            .cnt_i   (cnt_q),
            .rs_i    (issue_rs_i[k*REG_AW_P +: REG_AW_P]),
            .used_i  (issue_rs_used_i[k]),
            .hit_o   (hit[k]),
            .idx_o   (idx[k]),
            .ready_o (ready[k])
        );

        // A match in the last slot is already in the register file.
        assign nsel[k] = (hit[k] && (int'(idx[k]) + 1 != STAGES_P))
                       ? idx[k] + SEL_W'(1) : '0;
    end

    assign stall_o   = issue_valid_i & (|(hit & ~ready));
    assign accept    = issue_valid_i & ~stall_o & ~freeze_i;
    assign fwd_sel_o = sel_q;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!freeze_i) begin
            for (int i = 1; i < STAGES_P; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                cnt_d[i]   = (cnt_q[i-1] == '0) ? '0
                           : cnt_q[i-1] - LAT_W_P'(1);
            end
            valid_d[0] = accept & issue_wr_i;
            rd_d[0]    = issue_rd_i;
            cnt_d[0]   = (issue_lat_i == '0) ? LAT_W_P'(1) : issue_lat_i;
            sel_d      = accept ? nsel : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expected forward selects are queued
// when an instruction is driven and compared after the following clock edge.
module tb_fwd_scoreboard;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        freeze_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_wr_i;
    logic [1:0]  issue_lat_i;
    logic [9:0]  issue_rs_i;
    logic [1:0]  issue_rs_used_i;
    logic        stall_o;
    logic [3:0]  fwd_sel_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    fwd_scoreboard dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .freeze_i        (freeze_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_i      (issue_rd_i),
        .issue_wr_i      (issue_wr_i),
        .issue_lat_i     (issue_lat_i),
        .issue_rs_i      (issue_rs_i),
        .issue_rs_used_i (issue_rs_used_i),
        .stall_o         (stall_o),
        .fwd_sel_o       (fwd_sel_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (issue_valid_i && !rst_i) begin
            assert (issue_lat_i <= 2'(STAGES - 1)) else begin
                $display("FAIL lat_cfg lat=%0d max=%0d", issue_lat_i, STAGES - 1);
                $fatal(1, "latency exceeds tracked slots");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr,
                         input logic [1:0] lat, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [1:0] used);
        issue_valid_i   = v;
        issue_rd_i      = rd;
        issue_wr_i      = wr;
        issue_lat_i     = lat;
        issue_rs_i      = {rs1, rs0};
        issue_rs_used_i = used;
    endtask

    task automatic cycle(input string tag, input logic es,
                         input logic [1:0] s0, input logic [1:0] s1);
        logic [3:0] e;
        #1;
        check({tag, ".stall"}, 32'(stall_o), 32'(es));
        exp_q.push_back({s1, s0});
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check({tag, ".sel"}, 32'(fwd_sel_o), 32'(e));
    endtask

    initial begin
        rst_i    = 1'b1;
        freeze_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 5'd0, 2'b00);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("reset.stall", 32'(stall_o), 32'd0);
        check("reset.sel", 32'(fwd_sel_o), 32'd0);

        // ALU chain
        drive(1, 5'd5, 1, 2'(LAT_ALU), 5'd0, 5'd0, 2'b00);
        cycle("alu1", 0, 2'(FWD_RF), 2'(FWD_RF));
        drive(1, 5'd10, 1, 2'(LAT_ALU), 5'd5, 5'd0, 2'b01);
        cycle("alu2", 0, 2'(FWD_EXMEM), 2'(FWD_RF));
        drive(1, 5'd11, 1, 2'(LAT_ALU), 5'd0, 5'd5, 2'b10);
        cycle("alu3", 0, 2'(FWD_RF), 2'(FWD_MEMWB));

        // Load-use: one bubble, then forward from MEM/WB
        drive(1, 5'd7, 1, 2'(LAT_LOAD), 5'd0, 5'd0, 2'b00);
        cycle("ld1", 0, 0, 0);
        drive(1, 5'd12, 1, 2'(LAT_ALU), 5'd0, 5'd7, 2'b10);
        cycle("ld2", 1, 0, 0);
        cycle("ld3", 0, 0, 2'(FWD_MEMWB));

        // r0 never matches; unused operand never stalls
        drive(1, 5'd0, 1, 2'(LAT_LOAD), 5'd0, 5'd0, 2'b00);
        cycle("z1", 0, 0, 0);
        drive(1, 5'd13, 1, 2'(LAT_ALU), 5'd0, 5'd12, 2'b11);
        cycle("z2", 0, 0, 2'(FWD_MEMWB));
        drive(1, 5'd9, 1, 2'(LAT_LOAD), 5'd0, 5'd0, 2'b00);
        cycle("u1", 0, 0, 0);
        drive(1, 5'd14, 1, 2'(LAT_ALU), 5'd9, 5'd0, 2'b00);
        cycle("u2", 0, 0, 0);

        // Double producer: youngest wins
        drive(1, 5'd4, 1, 2'(LAT_ALU), 5'd0, 5'd0, 2'b00);
        cycle("d1", 0, 0, 0);
        cycle("d2", 0, 0, 0);
        drive(1, 5'd15, 1, 2'(LAT_ALU), 5'd4, 5'd0, 2'b01);
        cycle("d3", 0, 2'(FWD_EXMEM), 0);

        // Write-back drop
        drive(1, 5'd6, 1, 2'(LAT_ALU), 5'd0, 5'd0, 2'b00);
        cycle("w1", 0, 0, 0);
        drive(1, 5'd16, 1, 2'(LAT_ALU), 5'd0, 5'd0, 2'b00);
        cycle("w2", 0, 0, 0);
        drive(1, 5'd17, 1, 2'(LAT_ALU), 5'd0, 5'd0, 2'b00);
        cycle("w3", 0, 0, 0);
        drive(1, 5'd0, 0, 2'(LAT_ALU), 5'd6, 5'd17, 2'b11);
        cycle("w4", 0, 2'(FWD_RF), 2'(FWD_EXMEM));

        // Freeze during a load-use stall
        drive(1, 5'd8, 1, 2'(LAT_LOAD), 5'd17, 5'd0, 2'b01);
        cycle("f1", 0, 2'(FWD_MEMWB), 0);
        drive(1, 5'd18, 1, 2'(LAT_ALU), 5'd0, 5'd8, 2'b10);
        freeze_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("frz%0d", i), 1, 2'(FWD_MEMWB), 0);
        end
        freeze_i = 1'b0;
        cycle("f2", 1, 0, 0);
        cycle("f3", 0, 0, 2'(FWD_MEMWB));

        // Latency 0 behaves as ALU latency
        drive(1, 5'd20, 1, 2'd0, 5'd0, 5'd0, 2'b00);
        cycle("e1", 0, 0, 0);
        drive(1, 5'd21, 1, 2'(LAT_ALU), 5'd20, 5'd0, 2'b01);
        cycle("e2", 0, 2'(FWD_EXMEM), 0);

        // Reset overrides freeze and discards a pending load
        drive(1, 5'd19, 1, 2'(LAT_LOAD), 5'd0, 5'd0, 2'b00);
        rst_i    = 1'b1;
        freeze_i = 1'b1;
        cycle("r1", 0, 0, 0);
        rst_i    = 1'b0;
        freeze_i = 1'b0;
        drive(1, 5'd22, 1, 2'(LAT_ALU), 5'd19, 5'd21, 2'b11);
        cycle("r2", 0, 0, 0);

        drive(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00);
        @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
